// File: rtl/uart_fifo_pkg.sv
// Shared types and constants for the UART receive FIFO.
package uart_fifo_pkg;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_FIFO_DEPTH = 16;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
        logic overflow;
        logic underflow;
    } fifo_flags_t;

endpackage

// File: rtl/fifo_ram.sv
// Register array with one synchronous write port and one asynchronous read port.
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_rx_sync_fifo.sv
// Circular-buffer UART Rx FIFO with occupancy, almost-full, sticky errors and FWFT output.
// Optional per-entry error tag when FIFO_ERR_TAG_EN is defined.
module uart_rx_sync_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int AF_THRESH  = FIFO_DEPTH - 2
) (
    input  logic                        Clk,
    input  logic                        Rst_n,
    input  logic [DATA_BITS-1:0]        Rx_Data,
    input  logic                        Wr_En,
    input  logic                        Rd_En,
    input  logic                        Flush,
    input  logic                        Clr_Err,
    input  logic                        BIST_Mode,
    output logic [DATA_BITS-1:0]        Data_Out,
    output logic                        FIFO_Empty,
    output logic                        FIFO_Full,
    output logic                        Almost_Full,
    output logic                        FIFO_Overflow,
    output logic                        FIFO_Underflow,
    output logic [$clog2(FIFO_DEPTH):0] Count
`ifdef FIFO_ERR_TAG_EN
    ,
    input  logic                        Rx_Err,
    output logic                        Err_Out
`endif
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = cnt_width(FIFO_DEPTH);
`ifdef FIFO_ERR_TAG_EN
    localparam int MEM_W  = DATA_BITS + 1;
`else
    localparam int MEM_W  = DATA_BITS;
`endif
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);

    logic [ADDR_W-1:0] wptr_r;
    logic [ADDR_W-1:0] rptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              ovf_r;
    logic              udf_r;

    logic              rd_acc_s;
    logic              wr_acc_s;
    logic              ovf_set_s;
    logic              udf_set_s;
    logic              ram_we_s;
    logic [MEM_W-1:0]  ram_wdata_s;
    logic [MEM_W-1:0]  ram_rdata_s;
    fifo_flags_t       flags_s;

    assign flags_s.empty       = (count_r == {CNT_W{1'b0}});
    assign flags_s.full        = (count_r == DEPTH_C);
    assign flags_s.almost_full = (count_r >= AF_C);
    assign flags_s.overflow    = ovf_r;
    assign flags_s.underflow   = udf_r;

    // A full FIFO still takes a write when the head is popped in the same cycle.
    assign rd_acc_s  = Rd_En & ~flags_s.empty;
    assign wr_acc_s  = Wr_En & ~BIST_Mode & (~flags_s.full | rd_acc_s);
    assign ovf_set_s = Wr_En & ~BIST_Mode & flags_s.full & ~rd_acc_s;
    assign udf_set_s = Rd_En & flags_s.empty;
    assign ram_we_s  = wr_acc_s & ~Flush & Rst_n;

`ifdef FIFO_ERR_TAG_EN
    assign ram_wdata_s = {Rx_Err, Rx_Data};
`else
    assign ram_wdata_s = Rx_Data;
`endif

    fifo_ram #(
        .WIDTH (MEM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_ram (
        .clk   (Clk),
        .we    (ram_we_s),
        .waddr (wptr_r),
        .wdata (ram_wdata_s),
        .raddr (rptr_r),
        .rdata (ram_rdata_s)
    );

    // Pointer, occupancy and sticky error state.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            wptr_r  <= {ADDR_W{1'b0}};
            rptr_r  <= {ADDR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            ovf_r   <= 1'b0;
            udf_r   <= 1'b0;
        end else if (Flush) begin
            wptr_r  <= {ADDR_W{1'b0}};
            rptr_r  <= {ADDR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (wr_acc_s) begin
                wptr_r <= wptr_r + ADDR_W'(1);
            end
            if (rd_acc_s) begin
                rptr_r <= rptr_r + ADDR_W'(1);
            end
            count_r <= count_r + CNT_W'(wr_acc_s) - CNT_W'(rd_acc_s);
            ovf_r   <= ovf_set_s | (ovf_r & ~Clr_Err);
            udf_r   <= udf_set_s | (udf_r & ~Clr_Err);
        end
    end

    // First-word-fall-through head, blanked while empty.
    always_comb begin
        Data_Out = {DATA_BITS{1'b0}};
`ifdef FIFO_ERR_TAG_EN
        Err_Out  = 1'b0;
`endif
        if (!flags_s.empty) begin
            Data_Out = ram_rdata_s[DATA_BITS-1:0];
`ifdef FIFO_ERR_TAG_EN
            Err_Out  = ram_rdata_s[DATA_BITS];
`endif
        end else begin
            Data_Out = {DATA_BITS{1'b0}};
        end
    end

    assign FIFO_Empty     = flags_s.empty;
    assign FIFO_Full      = flags_s.full;
    assign Almost_Full    = flags_s.almost_full;
    assign FIFO_Overflow  = flags_s.overflow;
    assign FIFO_Underflow = flags_s.underflow;
    assign Count          = count_r;

endmodule

// File: tb/tb_uart_rx_sync_fifo.sv
// Directed bench for uart_rx_sync_fifo at depth 4, almost-full threshold 3.
module tb_uart_rx_sync_fifo;

    logic       Clk;
    logic       Rst_n;
    logic [7:0] Rx_Data;
    logic       Wr_En;
    logic       Rd_En;
    logic       Flush;
    logic       Clr_Err;
    logic       BIST_Mode;
    logic [7:0] Data_Out;
    logic       FIFO_Empty;
    logic       FIFO_Full;
    logic       Almost_Full;
    logic       FIFO_Overflow;
    logic       FIFO_Underflow;
    logic [2:0] Count;
`ifdef FIFO_ERR_TAG_EN
    logic       Rx_Err;
    logic       Err_Out;
`endif

    int checks;
    int errors;

    uart_rx_sync_fifo #(
        .DATA_BITS  (8),
        .FIFO_DEPTH (4),
        .AF_THRESH  (3)
    ) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .Rx_Data        (Rx_Data),
        .Wr_En          (Wr_En),
        .Rd_En          (Rd_En),
        .Flush          (Flush),
        .Clr_Err        (Clr_Err),
        .BIST_Mode      (BIST_Mode),
        .Data_Out       (Data_Out),
        .FIFO_Empty     (FIFO_Empty),
        .FIFO_Full      (FIFO_Full),
        .Almost_Full    (Almost_Full),
        .FIFO_Overflow  (FIFO_Overflow),
        .FIFO_Underflow (FIFO_Underflow),
        .Count          (Count)
`ifdef FIFO_ERR_TAG_EN
        ,
        .Rx_Err         (Rx_Err),
        .Err_Out        (Err_Out)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        Wr_En   = 1'b1;
        Rx_Data = d;
        cyc();
        Wr_En   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] exp);
        chk(tag, Data_Out, exp);
        Rd_En = 1'b1;
        cyc();
        Rd_En = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        Rst_n     = 1'b0;
        Rx_Data   = 8'h77;
        Wr_En     = 1'b1;
        Rd_En     = 1'b0;
        Flush     = 1'b0;
        Clr_Err   = 1'b0;
        BIST_Mode = 1'b0;
`ifdef FIFO_ERR_TAG_EN
        Rx_Err    = 1'b0;
`endif
        cyc();
        cyc();
        chk("rst_count", Count, 32'd0);
        chk("rst_empty", FIFO_Empty, 32'd1);
        chk("rst_dout", Data_Out, 32'h0);
        chk("rst_ovf", FIFO_Overflow, 32'd0);
        chk("rst_udf", FIFO_Underflow, 32'd0);
        Rst_n = 1'b1;
        Wr_En = 1'b0;
        cyc();
        chk("post_rst_count", Count, 32'd0);

        // Fill, partial drain, wrap, full drain
        wr(8'hA1);
        chk("fwft_dout", Data_Out, 32'hA1);
        chk("fwft_empty", FIFO_Empty, 32'd0);
        wr(8'hA2);
        wr(8'hA3);
        wr(8'hA4);
        chk("fill_full", FIFO_Full, 32'd1);
        chk("fill_count", Count, 32'd4);
        rd_chk("pop_a1", 8'hA1);
        rd_chk("pop_a2", 8'hA2);
        chk("half_count", Count, 32'd2);
        wr(8'hB1);
        wr(8'hB2);
        chk("wrap_full", FIFO_Full, 32'd1);
        rd_chk("pop_a3", 8'hA3);
        rd_chk("pop_a4", 8'hA4);
        rd_chk("pop_b1", 8'hB1);
        rd_chk("pop_b2", 8'hB2);
        chk("drain_empty", FIFO_Empty, 32'd1);
        chk("drain_dout", Data_Out, 32'h0);

        // Overflow on full, then write+read on full
        wr(8'hD0);
        wr(8'hD1);
        wr(8'hD2);
        wr(8'hD3);
        wr(8'hC5);
        chk("ovf_set", FIFO_Overflow, 32'd1);
        chk("ovf_count", Count, 32'd4);
        chk("ovf_head", Data_Out, 32'hD0);
        Wr_En   = 1'b1;
        Rd_En   = 1'b1;
        Rx_Data = 8'hC6;
        cyc();
        Wr_En   = 1'b0;
        Rd_En   = 1'b0;
        chk("wrrd_count", Count, 32'd4);
        chk("wrrd_ovf_sticky", FIFO_Overflow, 32'd1);
        rd_chk("pop_d1", 8'hD1);
        rd_chk("pop_d2", 8'hD2);
        rd_chk("pop_d3", 8'hD3);
        rd_chk("pop_c6", 8'hC6);
        chk("ovf_still", FIFO_Overflow, 32'd1);
        Clr_Err = 1'b1;
        cyc();
        Clr_Err = 1'b0;
        chk("ovf_clr", FIFO_Overflow, 32'd0);

        // Underflow: set beats same-cycle clear
        Rd_En   = 1'b1;
        Clr_Err = 1'b1;
        cyc();
        Rd_En   = 1'b0;
        Clr_Err = 1'b0;
        chk("udf_set_wins", FIFO_Underflow, 32'd1);
        chk("udf_count", Count, 32'd0);
        Clr_Err = 1'b1;
        cyc();
        Clr_Err = 1'b0;
        chk("udf_clr", FIFO_Underflow, 32'd0);
        Rd_En = 1'b1;
        cyc();
        Rd_En = 1'b0;
        chk("udf_set", FIFO_Underflow, 32'd1);

        // BIST blocks writes without flagging overflow
        BIST_Mode = 1'b1;
        wr(8'h55);
        BIST_Mode = 1'b0;
        chk("bist_count", Count, 32'd0);
        chk("bist_ovf", FIFO_Overflow, 32'd0);
        chk("bist_empty", FIFO_Empty, 32'd1);

        // Almost-full threshold and flush
        wr(8'h01);
        wr(8'h02);
        chk("af_below", Almost_Full, 32'd0);
        wr(8'h03);
        chk("af_at", Almost_Full, 32'd1);
        chk("af_full_clear", FIFO_Full, 32'd0);
        Flush   = 1'b1;
        Wr_En   = 1'b1;
        Rx_Data = 8'h99;
        cyc();
        Flush   = 1'b0;
        Wr_En   = 1'b0;
        chk("flush_count", Count, 32'd0);
        chk("flush_empty", FIFO_Empty, 32'd1);
        chk("flush_af", Almost_Full, 32'd0);
        chk("flush_udf_kept", FIFO_Underflow, 32'd1);
        chk("flush_dout", Data_Out, 32'h0);
        wr(8'h42);
        chk("post_flush_head", Data_Out, 32'h42);
        rd_chk("pop_42", 8'h42);

`ifdef FIFO_ERR_TAG_EN
        Rx_Err = 1'b1;
        wr(8'h10);
        Rx_Err = 1'b0;
        wr(8'h11);
        chk("tag_first", Err_Out, 32'd1);
        rd_chk("tag_pop_10", 8'h10);
        chk("tag_second", Err_Out, 32'd0);
        rd_chk("tag_pop_11", 8'h11);
        chk("tag_empty", Err_Out, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
